instr_fetch_unit: RTL and testbench

Front end of the RISC-V CPU. It generates sequential fetch addresses and issues them to instruction memory over a request/acknowledge interface. Returned instructions go into a small buffer and are presented to the controller's decode path with a valid/ready handshake. It consumes the controller's PC redirect (branch/jump/jalr) and flushes wrong-path instructions.

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential fetch address generation, single-outstanding imem requests, small instruction FIFO.
// Latency: a response pushed at edge N is visible at the decode head right after edge N (empty buffer); best case 1 instr / 2 cycles.
// Backpressure: instr_valid/instr_ready at the head; no imem request is issued while the buffer is full or a request is outstanding.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   imem_req/addr/ack     - fetch request channel (accepted on imem_req & imem_ack)
//   imem_rvalid/rdata     - in-order response channel, at most one response per accepted request
//   redirect/redirect_pc  - PC redirect from the controller; flushes the buffer and the in-flight fetch
//   instr_valid/ready     - decode handshake at the buffer head
//   instr/instr_pc        - head instruction and its address (0 when empty)
//   op/funct3/funct7b5    - decode slices of the head (0 when empty)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    // FETCH: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t            state_q;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       req_pc_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       buf_instr_q [BUF_DEPTH];
    logic [31:0]       buf_pc_q    [BUF_DEPTH];

    logic              accept_d;
    logic              push_d;
    logic              pop_d;
    logic [31:0]       redirect_pc_d;
    logic              unused_pc_bits;

    // The low address bits of a redirect target are dropped: fetch is word aligned
    assign redirect_pc_d  = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Request is gated by reset so the bus stays quiet for the whole reset pulse
    assign imem_req  = !reset && (state_q == S_FETCH) && (count_q < DEPTH_C);
    assign imem_addr = fetch_pc_q;

    assign accept_d    = imem_req && imem_ack;
    assign push_d      = (state_q == S_WAIT) && imem_rvalid;
    assign instr_valid = (count_q != '0);
    assign pop_d       = instr_valid && instr_ready;

    assign instr    = instr_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc = instr_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else if (redirect) begin
            // Flush overrides any push/pop this cycle; the in-flight request (if any) becomes wrong-path
            fetch_pc_q <= redirect_pc_d;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            case (state_q)
                S_FETCH: state_q <= accept_d ? S_DROP : S_FETCH;
                S_WAIT:  state_q <= imem_rvalid ? S_FETCH : S_DROP;
                // A response landing in DROP this cycle retires the only outstanding request,
                // so staying in DROP would wait for a response that never comes
                S_DROP:  state_q <= imem_rvalid ? S_FETCH : S_DROP;
                default: state_q <= S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (accept_d) begin
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT:  if (imem_rvalid) state_q <= S_FETCH;
                S_DROP:  if (imem_rvalid) state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase

            if (push_d) begin
                buf_instr_q[wr_ptr_q] <= imem_rdata;
                buf_pc_q[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_d, pop_d})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed phases followed by a randomized phase, checked every cycle
// against a queue-based reference model of the fetch/buffer behaviour plus a simple memory responder.
module tb_instr_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .op(op), .funct3(funct3), .funct7b5(funct7b5)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Reference model: buffered instructions, next fetch address, one in-flight request and whether it is wrong-path
    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_pend_pc;
    bit          m_out;
    bit          m_disc;

    // Memory responder
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    int ack_pct = 100;
    int rdy_pct = 100;
    int fix_lat = 1;
    bit chk_on  = 0;
    int passed  = 0;
    int total   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic bit m_req();
        return !reset && !m_out && (mq.size() < DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        ent_t h;
        bit   v;
        v = (mq.size() != 0);
        h = v ? mq[0] : '0;
        chk("imem_req", 32'(imem_req), 32'(m_req()));
        if (m_req()) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("instr_valid", 32'(instr_valid), 32'(v));
        chk("instr", instr, h.ins);
        chk("instr_pc", instr_pc, h.pc);
        chk("op", 32'(op), 32'(h.ins[6:0]));
        chk("funct3", 32'(funct3), 32'(h.ins[14:12]));
        chk("funct7b5", 32'(funct7b5), 32'(h.ins[30]));
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc);
        bit          rv, ak, rq, acc, resp, pop;
        int          lat;
        logic [31:0] rdat, pc_before;
        if (chk_on) check_outputs();
        rv   = mem_busy && (mem_cnt == 0);
        ak   = !mem_busy && ($urandom_range(99) < ack_pct);
        rdat = rv ? mem_word(mem_addr) : $urandom;
        reset       = rst;
        redirect    = redir;
        redirect_pc = redir ? rpc : $urandom;
        imem_rvalid = rv;
        imem_rdata  = rdat;
        imem_ack    = ak;
        instr_ready = ($urandom_range(99) < rdy_pct);
        rq   = m_req();
        @(posedge clk);
        acc  = rq && ak;
        resp = rv && m_out;
        pop  = (mq.size() != 0) && instr_ready;
        pc_before = m_fetch_pc;
        if (rst) begin
            mq.delete();
            m_fetch_pc = RPC;
            m_out      = 0;
            m_disc     = 0;
        end else if (redir) begin
            mq.delete();
            m_out      = (m_out && !resp) || acc;
            m_disc     = m_out;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (resp && !m_disc) mq.push_back('{pc: m_pend_pc, ins: rdat});
            if (resp) begin
                m_out  = 0;
                m_disc = 0;
            end
            if (acc) begin
                m_out      = 1;
                m_disc     = 0;
                m_pend_pc  = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        if (rv) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            lat      = (fix_lat > 0) ? fix_lat : int'($urandom_range(4, 1));
            mem_busy = 1;
            mem_cnt  = lat - 1;
            mem_addr = pc_before;
        end
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!m_req() && n < 50) begin
            cycle(0, 0, 32'h0);
            n++;
        end
        if (!m_req()) begin
            total++;
            $error("FAIL %s timeout waiting for request observed=none expected=request", tag);
        end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect = 0; redirect_pc = 0; instr_ready = 0;
        m_fetch_pc = RPC; m_pend_pc = 0; m_out = 0; m_disc = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        @(negedge clk);
        cycle(1, 0, 32'h0);
        chk_on = 1;
        cycle(1, 0, 32'h0);

        // 1: single-cycle memory, decode always ready
        cycle(0, 0, 32'h0);
        cycle(0, 0, 32'h0);
        chk("t1_op", 32'(op), 32'h13);
        chk("t1_funct3", 32'(funct3), 32'h0);
        chk("t1_pc", instr_pc, 32'h0);
        chk("t1_addr", imem_addr, 32'h4);
        repeat (8) cycle(0, 0, 32'h0);

        // 2: decode stalled, buffer fills and request stops
        rdy_pct = 0;
        repeat (10) cycle(0, 0, 32'h0);
        chk("t2_req_full", 32'(imem_req), 32'h0);
        chk("t2_valid_full", 32'(instr_valid), 32'h1);
        rdy_pct = 100;
        repeat (6) cycle(0, 0, 32'h0);

        // 3: redirect while waiting on a slow response
        fix_lat = 3;
        for (int i = 0; i < 50 && !(m_out && !m_disc); i++) cycle(0, 0, 32'h0);
        cycle(0, 1, 32'h100);
        chk("t3_valid_after_redirect", 32'(instr_valid), 32'h0);
        wait_req("t3_wait");
        chk("t3_addr", imem_addr, 32'h100);
        repeat (10) cycle(0, 0, 32'h0);

        // 4a: redirect coincident with the response
        fix_lat = 2;
        for (int i = 0; i < 50 && !(mem_busy && mem_cnt == 0 && m_out && !m_disc); i++) cycle(0, 0, 32'h0);
        cycle(0, 1, 32'h300);
        chk("t4a_req", 32'(imem_req), 32'h1);
        chk("t4a_addr", imem_addr, 32'h300);
        repeat (6) cycle(0, 0, 32'h0);

        // 4b: redirect coincident with request acceptance
        for (int i = 0; i < 50 && !(m_req() && !mem_busy); i++) cycle(0, 0, 32'h0);
        cycle(0, 1, 32'h400);
        chk("t4b_drop_req", 32'(imem_req), 32'h0);
        wait_req("t4b_wait");
        chk("t4b_addr", imem_addr, 32'h400);
        repeat (6) cycle(0, 0, 32'h0);

        // 5: misaligned target and address wrap
        cycle(0, 1, 32'h203);
        wait_req("t5_wait_a");
        chk("t5_align", imem_addr, 32'h200);
        cycle(0, 1, 32'hFFFF_FFFC);
        wait_req("t5_wait_b");
        chk("t5_top", imem_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 32'h0);
        wait_req("t5_wait_c");
        chk("t5_wrap", imem_addr, 32'h0);
        repeat (6) cycle(0, 0, 32'h0);

        // 6: reset mid-request with a stalled, non-empty buffer; the late response must be ignored
        fix_lat = 5;
        rdy_pct = 0;
        for (int i = 0; i < 50 && !(m_out && mq.size() >= 1); i++) cycle(0, 0, 32'h0);
        cycle(1, 0, 32'h0);
        chk("t6_valid", 32'(instr_valid), 32'h0);
        chk("t6_req", 32'(imem_req), 32'h0);
        cycle(1, 0, 32'h0);
        rdy_pct = 100;
        cycle(0, 0, 32'h0);
        chk("t6_restart_addr", imem_addr, RPC);
        repeat (15) cycle(0, 0, 32'h0);

        // 7: randomized traffic
        fix_lat = 0;
        ack_pct = 60;
        rdy_pct = 70;
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(199) == 0), ($urandom_range(99) < 6), $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
